// File: rtl/mem_fetch_unit.sv
// Memory fetch unit: turns the multicycle FSM's IorD/MemWE/IRWrite strobes into a
// req/ack transaction and holds IR/MDR. Optional watchdog enabled by MEM_TIMEOUT_EN.
module mem_fetch_unit #(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              IorD,
   input  logic              MemWE,
   input  logic              IRWrite,
   input  logic [ADDR_W-1:0] pc,
   input  logic [31:0]       aluout,
   input  logic [31:0]       wdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ack,
   output logic              stall,
   output logic [5:0]        opcode,
   output logic [4:0]        rs,
   output logic [4:0]        rt,
   output logic [4:0]        rd,
   output logic [4:0]        shamt,
   output logic [5:0]        funct,
   output logic [31:0]       imm_sext,
   output logic [25:0]       jtarget,
   output logic [31:0]       mdr,
   output logic              err
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state, state_nx;
   logic [31:0]       ir;
   logic              cap_fetch, cap_load;
   logic              acc_fetch, acc_store, acc_load, acc_any;
   logic [ADDR_W-1:0] addr_sel;
   logic              misal;
   logic              tmo;

   assign acc_fetch = IRWrite;
   assign acc_store = MemWE & ~IRWrite;
   assign acc_load  = IorD & ~MemWE & ~IRWrite;
   assign acc_any   = acc_fetch | acc_store | acc_load;
   assign addr_sel  = IorD ? aluout[ADDR_W-1:0] : pc;
   assign misal     = |addr_sel[1:0];

`ifdef MEM_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] tcnt;

   // Counts BUSY cycles without an ack; the TIMEOUT-th such cycle aborts.
   assign tmo = (state == BUSY) && !mem_ack && (tcnt == TW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (reset)
         tcnt <= '0;
      else if (state != BUSY)
         tcnt <= '0;
      else if (!mem_ack && !tmo)
         tcnt <= tcnt + TW'(1);
   end
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT > 0);
   assign tmo = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (acc_any && !misal) state_nx = BUSY;
         BUSY:    if (mem_ack || tmo)    state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ir        <= '0;
         mdr       <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         err       <= 1'b0;
         cap_fetch <= 1'b0;
         cap_load  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (acc_any) begin
               if (misal) begin
                  // Misaligned accesses never reach memory; a fetch becomes a nop.
                  err <= 1'b1;
                  if (acc_fetch) ir <= '0;
               end else begin
                  mem_req   <= 1'b1;
                  mem_we    <= acc_store;
                  mem_addr  <= addr_sel;
                  mem_wdata <= wdata;
                  cap_fetch <= acc_fetch;
                  cap_load  <= acc_load;
               end
            end
            BUSY: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  if (cap_fetch) ir  <= mem_rdata;
                  if (cap_load)  mdr <= mem_rdata;
               end else if (tmo) begin
                  mem_req <= 1'b0;
                  err     <= 1'b1;
                  if (cap_fetch) ir <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   // mem_req is high exactly while BUSY, which is also when the FSM must hold.
   assign stall    = mem_req;
   assign opcode   = ir[31:26];
   assign rs       = ir[25:21];
   assign rt       = ir[20:16];
   assign rd       = ir[15:11];
   assign shamt    = ir[10:6];
   assign funct    = ir[5:0];
   assign jtarget  = ir[25:0];
   assign imm_sext = {{16{ir[15]}}, ir[15:0]};

endmodule
